sha3_digest_collector: RTL and testbench
========================================

Name: sha3_digest_collector

Overview:
Sits directly downstream of AXI_SHA. It consumes AXI_SHA's 16-bit squeeze-out word stream (Mode_out qualified by Ready, terminated by Last) and keeps the leading digest words selected by ID (SHA3-224/256/384/512). It discards the rest of the state words, then re-emits the digest as a 32-bit valid/ready stream with a last marker toward the host/DMA side. It replaces the ad-hoc capture logic currently in the AXI_SHA bench with synthesizable RTL.

Parameters:
IN_W, 16, input word width; must equal AXI_SHA WIDTH; only 16 supported.
OUT_W, 32, output word width; fixed at 2*IN_W.
STATE_WORDS, 100, maximum input words per stream (1600/IN_W); used only for the overrun check.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  reset; asynchronous assert and synchronous deassert; resets all state.
id  in  2  digest select: 0=224, 1=256, 2=384, 3=512; sampled with the first input word.
in_valid  in  1  input word valid; driven by AXI_SHA Ready; there is no backpressure.
in_data  in  16  input word; driven by AXI_SHA Mode_out.
in_last  in  1  final word of the stream; driven by AXI_SHA Last.
m_valid  out  1  output word valid.
m_ready  in  1  downstream accept.
m_data  out  32  output word.
m_last  out  1  final digest word; qualified by m_valid.
busy  out  1  high in any state other than IDLE.
err_short  out  1  sticky; the stream ended before the digest was complete.
err_ovf  out  1  sticky; an input word arrived during SEND, or a stream exceeded STATE_WORDS.

Behaviour:
- Reset: state=IDLE. m_valid, m_last, busy, err_short, err_ovf are 0. m_data is 0. Counters are 0. Clearing the buffer is not required.
- Digest length N16 (16-bit words) and M32 (32-bit words) by sampled id:
  - id 0: N16=14, M32=7
  - id 1: N16=16, M32=8
  - id 2: N16=24, M32=12
  - id 3: N16=32, M32=16
- Buffer: 32 x 16-bit register array. Input word k is stored at index k.
- States IDLE, COLLECT, DRAIN, SEND.
- IDLE:
  - On in_valid: latch id, store word 0, set in_cnt=1.
  - If in_last is also set: set err_short and stay in IDLE.
  - Otherwise go to COLLECT.
- COLLECT: on each in_valid, store at in_cnt and increment in_cnt.
  - Word N16-1 with in_last: go to SEND.
  - Word N16-1 without in_last: go to DRAIN.
  - in_last before word N16-1: set err_short, go to IDLE, emit no output.
- DRAIN:
  - Ignore data but keep counting.
  - On in_last go to SEND.
  - If the count exceeds STATE_WORDS without in_last: set err_ovf and go to SEND anyway.
- SEND:
  - m_valid=1 starting the cycle after entry; latency from the in_last edge to first m_valid is 1 cycle.
  - m_data = {buf[2k], buf[2k+1]}. The earlier word goes in bits [31:16], so the first received word is most significant.
  - k advances only on m_valid&&m_ready. m_data, m_valid and m_last are held stable while m_ready=0.
  - m_last=1 when k=M32-1.
  - On acceptance of the last word: m_valid drops the next cycle, k=0, go to IDLE.
- in_valid during SEND: the word is dropped and err_ovf is set. The next stream is only recognised after the return to IDLE.
- The same-cycle return to IDLE and a new in_valid do not overlap: an input arriving in the final accept cycle counts as a SEND-state word.
- err_short and err_ovf are cleared only by ARESET.
- ARESET mid-stream (any state) aborts immediately. The output drops in the same cycle (asynchronous). The stream resumes in IDLE after deassert.
- Input words are not byte-swapped; lane byte order is the host's concern.

Test Plan:
- SHA3-256: id=1, 100 words with in_data=k (k=0..99), in_last on k=99, m_ready=1 -> 8 outputs 0x00000001, 0x00020003 ... 0x000E000F; m_last on the 8th; busy low after.
- SHA3-224: id=0, 100 words in_data=0xA000+k -> 7 outputs, last 0xA00CA00D with m_last=1; words 14..99 ignored.
- Backpressure: SHA3-512, m_ready toggling 1,0,0,1... -> 16 outputs in order with no duplicates or skips; m_data stable while stalled; final 0x001E001F.
- Short stream: id=2, 10 words, in_last on the 10th -> err_short=1, no m_valid, state returns to IDLE; the next full stream is still collected correctly.
- Overflow: during SEND with m_ready=0, pulse in_valid -> err_ovf=1 and output data unaffected. Also run a 120-word stream without in_last -> err_ovf=1 and the digest is emitted.
- Reset mid-SEND after 3 accepted words -> m_valid=0, busy=0 immediately. A following SHA3-384 stream yields 12 words starting from word 0.

Source files
------------

// File: rtl/sha3_digest_collector.sv
// -----------------------------------------------------------------------------
// sha3_digest_collector
//
// Purpose:
//   Captures the leading digest words from the AXI_SHA squeeze-out stream and
//   re-emits them as a 32-bit valid/ready stream.
//   - The input is a stream of 16-bit words. in_valid is AXI_SHA Ready,
//     in_data is Mode_out and in_last is Last. The input has no backpressure.
//   - id is sampled with the first word and selects the digest length.
//   - The first N16 words of the stream are buffered. The rest of the
//     permutation state is counted and then discarded.
//   - The digest is sent as M32 words of 32 bits. Each output word packs two
//     input words, and the earlier input word sits in bits [31:16].
//
// Ports:
//   ACLK       clock; all logic is on the rising edge
//   ARESET     active-high reset; asynchronous assert
//   id         digest select: 0=224, 1=256, 2=384, 3=512
//   in_valid   input word strobe
//   in_data    input word
//   in_last    final word of the input stream
//   m_valid    output word valid
//   m_ready    downstream accept
//   m_data     output word; the first received word is most significant
//   m_last     final digest word; qualified by m_valid
//   busy       high whenever the FSM is not in IDLE
//   err_short  sticky; the stream ended before the digest was complete
//   err_ovf    sticky; a word arrived during SEND, or a stream ran past
//              STATE_WORDS words
//
// Output handshake:
//   An output word transfers on every rising edge where m_valid && m_ready.
//   While m_valid is high and m_ready is low, m_data, m_valid and m_last are
//   held stable. m_valid never depends on m_ready.
//
// Reset:
//   ARESET is expected to be released synchronously to ACLK by the reset
//   network upstream. The outputs are decoded from registers that reset
//   asynchronously, so they drop in the same cycle that ARESET asserts.
// -----------------------------------------------------------------------------
module sha3_digest_collector #(
  parameter int IN_W        = 16,
  parameter int OUT_W       = 32,
  parameter int STATE_WORDS = 100
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [1:0]       id,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             err_short,
  output logic             err_ovf
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DRAIN   = 2'd2;
  localparam logic [1:0] S_SEND    = 2'd3;

  // The count compared against STATE_WORDS has 8 bits. This is enough for
  // STATE_WORDS + 1 at the default of 100.
  localparam logic [7:0] STATE_WORDS_C = 8'(STATE_WORDS);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [1:0]      id_q, id_d;
  logic [7:0]      in_cnt_q, in_cnt_d;   // number of words seen in this stream
  logic [3:0]      out_k_q, out_k_d;     // index of the current output word
  logic            err_short_q, err_ovf_q;
  logic            set_short, set_ovf;

  // Digest buffer. It is only written while collecting, and it is never read
  // before it has been written. It therefore needs no reset.
  logic [IN_W-1:0] dig_buf [32];
  logic            wr_en;
  logic [4:0]      wr_idx;

  // ---------------------------------------------------------------------------
  // Digest geometry for the latched id
  // ---------------------------------------------------------------------------
  logic [7:0] n16_m1;   // index of the last digest word on the input side
  logic [3:0] m32_m1;   // index of the last digest word on the output side

  always_comb begin
    n16_m1 = 8'd13;
    m32_m1 = 4'd6;
    case (id_q)
      2'd0: begin n16_m1 = 8'd13; m32_m1 = 4'd6;  end  // SHA3-224
      2'd1: begin n16_m1 = 8'd15; m32_m1 = 4'd7;  end  // SHA3-256
      2'd2: begin n16_m1 = 8'd23; m32_m1 = 4'd11; end  // SHA3-384
      2'd3: begin n16_m1 = 8'd31; m32_m1 = 4'd15; end  // SHA3-512
      default: begin n16_m1 = 8'd13; m32_m1 = 4'd6; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    in_cnt_d  = in_cnt_q;
    out_k_d   = out_k_q;
    set_short = 1'b0;
    set_ovf   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = in_cnt_q[4:0];

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Word 0 opens a stream. id is only taken from this word.
          id_d     = id;
          wr_en    = 1'b1;
          wr_idx   = 5'd0;
          in_cnt_d = 8'd1;
          if (in_last) begin
            // A stream of one word cannot hold any digest.
            set_short = 1'b1;
            in_cnt_d  = 8'd0;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end

      S_COLLECT: begin
        // In this state in_cnt stays below N16, which is at most 32. Its low
        // five bits therefore address the buffer directly.
        if (in_valid) begin
          wr_en    = 1'b1;
          in_cnt_d = in_cnt_q + 8'd1;
          if (in_cnt_q == n16_m1) begin
            state_d = in_last ? S_SEND : S_DRAIN;
          end else if (in_last) begin
            set_short = 1'b1;
            in_cnt_d  = 8'd0;
            state_d   = S_IDLE;
          end
        end
      end

      S_DRAIN: begin
        if (in_valid) begin
          in_cnt_d = in_cnt_q + 8'd1;
          if (in_last) begin
            state_d = S_SEND;
          end else if (in_cnt_d > STATE_WORDS_C) begin
            // The stream is longer than one permutation state and no Last was
            // seen. Flag the overrun, but still deliver what was captured.
            set_ovf = 1'b1;
            state_d = S_SEND;
          end
        end
      end

      S_SEND: begin
        // No input word can be accepted here. Any word that arrives is lost,
        // and this includes a word in the cycle of the final handshake.
        if (in_valid) begin
          set_ovf = 1'b1;
        end
        // m_valid is always high in SEND, so m_ready alone marks a handshake.
        if (m_ready) begin
          if (out_k_q == m32_m1) begin
            out_k_d  = 4'd0;
            in_cnt_d = 8'd0;
            state_d  = S_IDLE;
          end else begin
            out_k_d = out_k_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      id_q        <= 2'd0;
      in_cnt_q    <= 8'd0;
      out_k_q     <= 4'd0;
      err_short_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      in_cnt_q  <= in_cnt_d;
      out_k_q   <= out_k_d;
      if (set_short) begin
        err_short_q <= 1'b1;
      end
      if (set_ovf) begin
        err_ovf_q <= 1'b1;
      end
    end
  end

  // Buffer write port; this register file has no reset.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      dig_buf[wr_idx] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // m_valid is the SEND state itself. It therefore rises in the cycle after
  // the edge that captures the final needed word, and it falls as soon as
  // reset asserts. While SEND lasts, neither out_k nor the buffer can change
  // unless a handshake happens. This keeps the output stable during a stall.
  assign m_valid   = (state_q == S_SEND);
  assign m_last    = m_valid && (out_k_q == m32_m1);
  assign m_data    = m_valid ? {dig_buf[{out_k_q, 1'b0}], dig_buf[{out_k_q, 1'b1}]}
                             : '0;
  assign busy      = (state_q != S_IDLE);
  assign err_short = err_short_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_sha3_digest_collector.sv
// -----------------------------------------------------------------------------
// tb_sha3_digest_collector
//
// Self-checking bench for sha3_digest_collector.
//   - A reference model works from the received word list and the digest size
//     in bits. It predicts the 32-bit digest words, the sticky error flags and
//     whether an output phase follows.
//   - The expected digest words are held in exp_q.
//   - The stimulus runs as a linear sequence of directed and randomized steps.
// -----------------------------------------------------------------------------
module tb_sha3_digest_collector;

  localparam int STATE_WORDS = 100;

  // Clock and reset
  logic ACLK = 1'b0;
  logic ARESET;
  always #5 ACLK = ~ACLK;

  // DUT signals
  logic [1:0]  id;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        err_short;
  logic        err_ovf;

  sha3_digest_collector dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .id        (id),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .err_short (err_short),
    .err_ovf   (err_ovf)
  );

  // Scoreboard and model state
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [15:0] fed_q[$];
  bit          exp_short;
  bit          exp_ovf;
  bit          exp_send;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Digest length in 16-bit words, taken from the digest size in bits.
  function automatic int n16_of(input logic [1:0] sid);
    int bits;
    case (sid)
      2'd0:    bits = 224;
      2'd1:    bits = 256;
      2'd2:    bits = 384;
      default: bits = 512;
    endcase
    return bits / 16;
  endfunction

  // Reference model. It predicts the outcome of the stream held in fed_q.
  task automatic model(input logic [1:0] sid, input bit with_last);
    int n;
    n = n16_of(sid);
    if (with_last && fed_q.size() < n) begin
      exp_short = 1'b1;
      exp_send  = 1'b0;
    end else begin
      exp_send = 1'b1;
      // There are two overflow cases:
      //   - No Last arrived within one permutation state.
      //   - Words arrived after the output phase had started.
      if (!with_last || fed_q.size() > STATE_WORDS + 1) begin
        exp_ovf = 1'b1;
      end
      for (int i = 0; i < n / 2; i++) begin
        exp_q.push_back({fed_q[2*i], fed_q[2*i+1]});
      end
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    ARESET   = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    id       = '0;
    m_ready  = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_short", 32'(err_short), 32'd0);
    check("rst_err_ovf", 32'(err_ovf), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    ARESET = 1'b0;
    exp_q.delete();
    exp_short = 1'b0;
    exp_ovf   = 1'b0;
    exp_send  = 1'b0;
  endtask

  // dmode 0 drives base+k on each word. Any other dmode drives random data.
  // Only the first word carries the intended id. The later words carry
  // random ids, which the DUT must ignore.
  task automatic feed(input logic [1:0] sid, input int len, input bit with_last,
                      input int dmode, input logic [15:0] base, input bit gaps);
    fed_q.delete();
    m_ready = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge ACLK);
          #1;
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
      @(posedge ACLK);
      #1;
      in_valid = 1'b1;
      in_data  = (dmode == 0) ? base + 16'(k) : 16'($urandom);
      in_last  = with_last && (k == len - 1);
      id       = (k == 0) ? sid : 2'($urandom);
      fed_q.push_back(in_data);
    end
    @(posedge ACLK);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    model(sid, with_last);
    @(negedge ACLK);
    check("send_latency", 32'(m_valid), 32'(exp_send));
    check("busy_after_feed", 32'(busy), 32'(exp_send));
    check("err_short", 32'(err_short), 32'(exp_short));
    check("err_ovf", 32'(err_ovf), 32'(exp_ovf));
    if (exp_send) begin
      check("first_word", m_data, exp_q[0]);
    end
  endtask

  // mode 0: m_ready is always 1.
  // mode 1: m_ready follows the repeating pattern 1,0,0.
  // mode 2: m_ready is random.
  // stop_after > 0 ends the task after that many accepted words. The last of
  // those accepts happens on the edge that follows the task's return.
  task automatic drain(input int mode, input int stop_after);
    int accepted;
    bit done;
    accepted = 0;
    done     = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(posedge ACLK);
      #1;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge ACLK);
      if (exp_q.size() == 0) begin
        check("extra_valid", 32'(m_valid), 32'd0);
      end else begin
        check("out_valid", 32'(m_valid), 32'd1);
        check("out_data", m_data, exp_q[0]);
        check("out_last", 32'(m_last), 32'(exp_q.size() == 1));
        if (m_valid && m_ready) begin
          void'(exp_q.pop_front());
          accepted++;
          if (exp_q.size() == 0 || accepted == stop_after) begin
            done = 1'b1;
          end
        end
      end
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  // Let the final accept happen, then check that the block is idle again.
  task automatic finish_send();
    @(posedge ACLK);
    #1;
    m_ready = 1'b0;
    @(negedge ACLK);
    check("valid_drop", 32'(m_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic watch_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      check("no_output", 32'(m_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end
  endtask

  // Directed and randomized sequence
  logic [1:0] r_sid;
  int         r_n;
  int         r_len;
  bit         r_short;

  initial begin
    ARESET = 1'b1;
    do_reset();

    // SHA3-256; in_data = k; m_ready held high
    feed(2'd1, 100, 1'b1, 0, 16'h0000, 1'b0);
    drain(0, 0);
    finish_send();

    // SHA3-224; in_data = 0xA000 + k
    feed(2'd0, 100, 1'b1, 0, 16'hA000, 1'b0);
    drain(0, 0);
    finish_send();

    // SHA3-512 with m_ready pattern 1,0,0
    feed(2'd3, 100, 1'b1, 0, 16'h0000, 1'b0);
    drain(1, 0);
    finish_send();

    // Short SHA3-384 stream, then a full stream to show recovery
    feed(2'd2, 10, 1'b1, 1, 16'h0000, 1'b0);
    watch_idle(4);
    feed(2'd2, 100, 1'b1, 1, 16'h0000, 1'b1);
    drain(2, 0);
    finish_send();

    // A word arrives while SEND is stalled
    feed(2'd1, 100, 1'b1, 1, 16'h0000, 1'b0);
    @(posedge ACLK);
    #1;
    in_valid = 1'b1;
    in_data  = 16'($urandom);
    in_last  = 1'b1;
    id       = 2'($urandom);
    @(posedge ACLK);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_ovf  = 1'b1;
    @(negedge ACLK);
    check("ovf_pulse_flag", 32'(err_ovf), 32'd1);
    check("ovf_pulse_valid", 32'(m_valid), 32'd1);
    check("ovf_pulse_data", m_data, exp_q[0]);
    drain(1, 0);
    finish_send();

    // A 120-word stream with no Last
    do_reset();
    feed(2'd3, 120, 1'b0, 1, 16'h0000, 1'b0);
    drain(0, 0);
    finish_send();

    // Reset during SEND, after 3 accepted words
    do_reset();
    feed(2'd1, 100, 1'b1, 1, 16'h0000, 1'b0);
    drain(0, 3);
    @(posedge ACLK);
    #1;
    ARESET = 1'b1;
    #1;
    check("abort_m_valid", 32'(m_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_m_last", 32'(m_last), 32'd0);
    check("abort_m_data", m_data, 32'd0);
    exp_q.delete();
    exp_short = 1'b0;
    exp_ovf   = 1'b0;
    @(posedge ACLK);
    #1;
    ARESET  = 1'b0;
    m_ready = 1'b0;
    feed(2'd2, 100, 1'b1, 0, 16'h0000, 1'b0);
    drain(0, 0);
    finish_send();

    // Boundary cases:
    //   - a single word carrying Last
    //   - a stream of exactly the digest length
    //   - Last on the 101st word, which does not overflow
    feed(2'd3, 1, 1'b1, 1, 16'h0000, 1'b0);
    watch_idle(2);
    feed(2'd0, 14, 1'b1, 1, 16'h0000, 1'b0);
    drain(0, 0);
    finish_send();
    feed(2'd3, 101, 1'b1, 1, 16'h0000, 1'b0);
    drain(2, 0);
    finish_send();

    // Randomized streams
    for (int r = 0; r < 8; r++) begin
      r_sid   = 2'($urandom_range(0, 3));
      r_n     = n16_of(r_sid);
      r_short = ($urandom_range(0, 4) == 0);
      r_len   = r_short ? int'($urandom_range(1, r_n - 1))
                        : int'($urandom_range(r_n, STATE_WORDS + 1));
      feed(r_sid, r_len, 1'b1, 1, 16'h0000, 1'b1);
      if (exp_send) begin
        drain(2, 0);
        finish_send();
      end else begin
        watch_idle(2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
